// File: rtl/lit_init_reg_bank.sv
// lit_init_reg_bank: a small defaults-backed register bank.
// Every entry powers up and resets to its own literal taken from INIT_VALUES.
// The bank has one write port, a registered read port with one cycle of latency,
// per-entry dirty flags, and a restore engine. The restore engine rewrites the
// defaults one entry per cycle.

module lit_init_reg_bank #(
  parameter int                     WIDTH       = 8,
  parameter int                     DEPTH       = 4,
  parameter logic [DEPTH*WIDTH-1:0] INIT_VALUES = {8'd40, 8'd30, 8'd20, 8'd10},
  localparam int                    AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             restore_req,
  output logic             busy,
  output logic             wr_err,
  output logic [DEPTH-1:0] dirty
);

  typedef enum logic {
    S_IDLE,
    S_RESTORE
  } state_e;

  // DEPTH is widened by one bit, so that for non-power-of-two depths
  // an address from DEPTH up to 2**AW-1 can be detected.
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_ok;

  // Default literal for entry i.
  function automatic logic [WIDTH-1:0] init_entry(input int i);
    return INIT_VALUES[i*WIDTH +: WIDTH];
  endfunction

  // Next-state logic: write port, read port, and the restore sequencer.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves a value
    // unassigned and no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    mem_d      = mem_q;
    dirty_d    = dirty_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    busy_d     = busy_q;
    wr_err_d   = 1'b0;

    // A write is accepted only while idle and only for an address that exists.
    wr_ok = wr_en && !busy_q && ({1'b0, wr_addr} < DEPTH_EXT);
    if (wr_en && !wr_ok) begin
      wr_err_d = 1'b1;
    end

    // The read samples the pre-edge contents, so a same-cycle write returns the old value.
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr == AW'(i)) begin
          rd_data_d = mem_q[i];
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (wr_addr == AW'(i))) begin
        mem_d[i]   = wr_data;
        dirty_d[i] = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (restore_req) begin
          state_d = S_RESTORE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RESTORE: begin
        // No write is accepted while busy, so this update never collides with the write port.
        for (int i = 0; i < DEPTH; i++) begin
          if (idx_q == AW'(i)) begin
            mem_d[i]   = init_entry(i);
            dirty_d[i] = 1'b0;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset loads the literal defaults asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      // NOTE: this storage array is reset on purpose. Its reset values are the
      // defaults that the block provides, so this is not an ordinary RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_entry(i);
      end
      dirty_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop updates from pre-edge values.
      state_q    <= state_d;
      idx_q      <= idx_d;
      mem_q      <= mem_d;
      dirty_q    <= dirty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign wr_err   = wr_err_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_lit_init_reg_bank.sv
// Testbench for lit_init_reg_bank.
// Instance A uses the defaults (8 bits x 4 entries).
// Instance B uses 12 bits x 5 entries with defaults 0x001..0x005.
// A behavioural model keeps expected contents as plain arrays. It tracks a
// restore as a countdown of remaining entries.

module tb_lit_init_reg_bank;

  localparam int DA = 4;
  localparam int WA = 8;
  localparam int DB = 5;
  localparam int WB = 12;

  logic clk = 1'b0;
  logic reset;

  logic          a_wr_en, a_rd_en, a_restore;
  logic [1:0]    a_wr_addr, a_rd_addr;
  logic [WA-1:0] a_wr_data, a_rd_data;
  logic          a_rd_valid, a_busy, a_wr_err;
  logic [DA-1:0] a_dirty;

  logic          b_wr_en, b_rd_en, b_restore;
  logic [2:0]    b_wr_addr, b_rd_addr;
  logic [WB-1:0] b_wr_data, b_rd_data;
  logic          b_rd_valid, b_busy, b_wr_err;
  logic [DB-1:0] b_dirty;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, indexed [instance][entry].
  logic [11:0] m_init [2][5];
  logic [11:0] m_mem  [2][5];
  logic [4:0]  m_dirty[2];
  int          m_left [2];
  logic [11:0] m_rd   [2];
  logic        m_rv   [2];
  logic        m_we   [2];

  always #5 clk = ~clk;

  lit_init_reg_bank dut_a (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .restore_req(a_restore), .busy(a_busy), .wr_err(a_wr_err), .dirty(a_dirty)
  );

  lit_init_reg_bank #(
    .WIDTH(WB), .DEPTH(DB),
    .INIT_VALUES({12'h005, 12'h004, 12'h003, 12'h002, 12'h001})
  ) dut_b (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .restore_req(b_restore), .busy(b_busy), .wr_err(b_wr_err), .dirty(b_dirty)
  );

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 5; i++) m_mem[s][i] = m_init[s][i];
      m_dirty[s] = '0;
      m_left[s]  = 0;
      m_rd[s]    = '0;
      m_rv[s]    = 1'b0;
      m_we[s]    = 1'b0;
    end
  endtask

  // Applies one rising edge to model instance s.
  task automatic model_edge(input int s, input int depth, input logic we, input int wa,
                            input logic [11:0] wd, input logic re, input int ra, input logic rr);
    logic bsy;
    int   k;
    bsy = (m_left[s] > 0);
    if (re) m_rd[s] = (ra < depth) ? m_mem[s][ra] : 12'h000;
    m_rv[s] = re;
    m_we[s] = we && (bsy || wa >= depth);
    if (we && !bsy && wa < depth) begin
      m_mem[s][wa]   = wd;
      m_dirty[s][wa] = 1'b1;
    end
    if (bsy) begin
      k = depth - m_left[s];
      m_mem[s][k]   = m_init[s][k];
      m_dirty[s][k] = 1'b0;
      m_left[s]     = m_left[s] - 1;
    end else if (rr) begin
      m_left[s] = depth;
    end
  endtask

  // Advances one clock. Outputs are then sampled 1 time unit after the edge.
  task automatic step();
    if (!reset) begin
      model_edge(0, DA, a_wr_en, int'(a_wr_addr), 12'(a_wr_data), a_rd_en, int'(a_rd_addr), a_restore);
      model_edge(1, DB, b_wr_en, int'(b_wr_addr), b_wr_data, b_rd_en, int'(b_rd_addr), b_restore);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_wr_en = 0; a_rd_en = 0; a_restore = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0;
    b_wr_en = 0; b_rd_en = 0; b_restore = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
    n_checks++; if (a_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", a_rd_data); end
    n_checks++; if (a_wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err got=%b exp=0", a_wr_err); end
    n_checks++; if (a_dirty !== 4'b0000) begin n_fail++; $display("FAIL reset_dirty got=%b exp=0000", a_dirty); end
    n_checks++; if (b_dirty !== 5'b00000) begin n_fail++; $display("FAIL reset_b_dirty got=%b exp=00000", b_dirty); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_defaults();
    logic [7:0] exp_v [4];
    exp_v = '{8'h0A, 8'h14, 8'h1E, 8'h28};
    for (int i = 0; i < 4; i++) begin
      a_rd_en = 1; a_rd_addr = 2'(i);
      step();
      n_checks++; if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL defaults_valid%0d got=%b exp=1", i, a_rd_valid); end
      n_checks++; if (a_rd_data !== exp_v[i]) begin n_fail++; $display("FAIL defaults_data%0d got=%h exp=%h", i, a_rd_data, exp_v[i]); end
    end
    a_rd_en = 0;
    step();
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL defaults_valid_drop got=%b exp=0", a_rd_valid); end
    n_checks++; if (a_rd_data !== 8'h28) begin n_fail++; $display("FAIL defaults_hold got=%h exp=28", a_rd_data); end
    n_checks++; if (a_dirty !== 4'b0000) begin n_fail++; $display("FAIL defaults_dirty got=%b exp=0000", a_dirty); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL defaults_busy got=%b exp=0", a_busy); end
  endtask

  task automatic test_write_read();
    a_wr_en = 1; a_wr_addr = 2; a_wr_data = 8'h55; a_rd_en = 1; a_rd_addr = 2;
    step();
    a_wr_en = 0;
    n_checks++; if (a_rd_data !== 8'h1E) begin n_fail++; $display("FAIL rbw_old_data got=%h exp=1e", a_rd_data); end
    n_checks++; if (a_dirty !== 4'b0100) begin n_fail++; $display("FAIL wr_dirty got=%b exp=0100", a_dirty); end
    n_checks++; if (a_wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_accept_err got=%b exp=0", a_wr_err); end
    step();
    a_rd_en = 0;
    n_checks++; if (a_rd_data !== 8'h55) begin n_fail++; $display("FAIL wr_new_data got=%h exp=55", a_rd_data); end
  endtask

  task automatic test_restore();
    int cnt, guard;
    a_restore = 1;
    step();
    a_restore = 0;
    cnt = a_busy ? 1 : 0;
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 8'h77;
    step();
    a_wr_en = 0;
    if (a_busy) cnt++;
    n_checks++; if (a_wr_err !== 1'b1) begin n_fail++; $display("FAIL busy_wr_err got=%b exp=1", a_wr_err); end
    n_checks++; if (a_dirty !== 4'b0100) begin n_fail++; $display("FAIL busy_wr_dirty got=%b exp=0100", a_dirty); end
    step();
    if (a_busy) cnt++;
    n_checks++; if (a_wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_pulse got=%b exp=0", a_wr_err); end
    guard = 0;
    while (a_busy && guard < 20) begin
      step();
      if (a_busy) cnt++;
      guard++;
    end
    n_checks++; if (cnt != 4) begin n_fail++; $display("FAIL restore_busy_cycles got=%0d exp=4", cnt); end
    n_checks++; if (a_dirty !== 4'b0000) begin n_fail++; $display("FAIL restore_dirty got=%b exp=0000", a_dirty); end
    a_rd_en = 1; a_rd_addr = 2;
    step();
    n_checks++; if (a_rd_data !== 8'h1E) begin n_fail++; $display("FAIL restore_addr2 got=%h exp=1e", a_rd_data); end
    a_rd_addr = 1;
    step();
    a_rd_en = 0;
    n_checks++; if (a_rd_data !== 8'h14) begin n_fail++; $display("FAIL restore_addr1 got=%h exp=14", a_rd_data); end
  endtask

  task automatic test_nonpow2();
    int cnt, guard;
    b_wr_en = 1; b_wr_addr = 4; b_wr_data = 12'hABC;
    step();
    n_checks++; if (b_dirty !== 5'b10000) begin n_fail++; $display("FAIL np2_dirty got=%b exp=10000", b_dirty); end
    b_wr_addr = 6; b_wr_data = 12'h123;
    step();
    b_wr_en = 0;
    n_checks++; if (b_wr_err !== 1'b1) begin n_fail++; $display("FAIL np2_oob_wr_err got=%b exp=1", b_wr_err); end
    n_checks++; if (b_dirty !== 5'b10000) begin n_fail++; $display("FAIL np2_oob_dirty got=%b exp=10000", b_dirty); end
    b_rd_en = 1; b_rd_addr = 6;
    step();
    n_checks++; if (b_rd_data !== 12'h000 || b_rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL np2_oob_read got=%h/%b exp=000/1", b_rd_data, b_rd_valid); end
    b_rd_addr = 4;
    step();
    b_rd_en = 0;
    n_checks++; if (b_rd_data !== 12'hABC) begin n_fail++; $display("FAIL np2_read4 got=%h exp=abc", b_rd_data); end
    b_restore = 1;
    step();
    b_restore = 0;
    cnt = b_busy ? 1 : 0;
    guard = 0;
    while (b_busy && guard < 20) begin
      step();
      if (b_busy) cnt++;
      guard++;
    end
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL np2_busy_cycles got=%0d exp=5", cnt); end
    b_rd_en = 1; b_rd_addr = 4;
    step();
    b_rd_en = 0;
    n_checks++; if (b_rd_data !== 12'h005) begin n_fail++; $display("FAIL np2_restored4 got=%h exp=005", b_rd_data); end
    n_checks++; if (b_dirty !== 5'b00000) begin n_fail++; $display("FAIL np2_restore_dirty got=%b exp=00000", b_dirty); end
  endtask

  task automatic test_reset_mid_restore();
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 8'hAA;
    step();
    a_wr_en = 0; a_restore = 1;
    step();
    a_restore = 0; a_rd_en = 1; a_rd_addr = 0;
    step();
    step();
    a_rd_en = 0;
    n_checks++; if (a_busy !== 1'b1 || a_rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre busy/valid got=%b/%b exp=1/1", a_busy, a_rd_valid); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid got=%b exp=0", a_rd_valid); end
    n_checks++; if (a_dirty !== 4'b0000) begin n_fail++; $display("FAIL midrst_async_dirty got=%b exp=0000", a_dirty); end
    @(posedge clk);
    #1 reset = 1'b0;
    a_rd_en = 1; a_rd_addr = 3;
    step();
    a_rd_en = 0;
    n_checks++; if (a_rd_data !== 8'h28) begin n_fail++; $display("FAIL midrst_addr3 got=%h exp=28", a_rd_data); end
    n_checks++; if (a_dirty !== 4'b0000) begin n_fail++; $display("FAIL midrst_dirty got=%b exp=0000", a_dirty); end
  endtask

  task automatic test_simultaneous();
    int guard;
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 8'h99; a_restore = 1;
    step();
    a_wr_en = 0; a_restore = 0;
    n_checks++; if (a_wr_err !== 1'b0) begin n_fail++; $display("FAIL sim_wr_err got=%b exp=0", a_wr_err); end
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy got=%b exp=1", a_busy); end
    n_checks++; if (a_dirty !== 4'b0001) begin n_fail++; $display("FAIL sim_dirty got=%b exp=0001", a_dirty); end
    guard = 0;
    while (a_busy && guard < 20) begin
      step();
      guard++;
    end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL sim_busy_timeout got=%b exp=0", a_busy); end
    a_rd_en = 1; a_rd_addr = 0;
    step();
    a_rd_en = 0;
    n_checks++; if (a_rd_data !== 8'h0A) begin n_fail++; $display("FAIL sim_addr0 got=%h exp=0a", a_rd_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a_wr_en = 1'($urandom); a_wr_addr = 2'($urandom); a_wr_data = 8'($urandom);
      a_rd_en = 1'($urandom); a_rd_addr = 2'($urandom); a_restore = ($urandom_range(0, 15) == 0);
      b_wr_en = 1'($urandom); b_wr_addr = 3'($urandom); b_wr_data = 12'($urandom);
      b_rd_en = 1'($urandom); b_rd_addr = 3'($urandom); b_restore = ($urandom_range(0, 15) == 0);
      step();
      n_checks++; if (a_rd_data !== m_rd[0][7:0] || a_rd_valid !== m_rv[0]) begin
        n_fail++; $display("FAIL rand_a_read cyc=%0d got=%h/%b exp=%h/%b", n, a_rd_data, a_rd_valid, m_rd[0][7:0], m_rv[0]); end
      n_checks++; if (a_busy !== (m_left[0] > 0) || a_wr_err !== m_we[0] || a_dirty !== m_dirty[0][3:0]) begin
        n_fail++; $display("FAIL rand_a_ctrl cyc=%0d got=%b/%b/%b exp=%b/%b/%b", n, a_busy, a_wr_err, a_dirty,
                           (m_left[0] > 0), m_we[0], m_dirty[0][3:0]); end
      n_checks++; if (b_rd_data !== m_rd[1] || b_rd_valid !== m_rv[1]) begin
        n_fail++; $display("FAIL rand_b_read cyc=%0d got=%h/%b exp=%h/%b", n, b_rd_data, b_rd_valid, m_rd[1], m_rv[1]); end
      n_checks++; if (b_busy !== (m_left[1] > 0) || b_wr_err !== m_we[1] || b_dirty !== m_dirty[1]) begin
        n_fail++; $display("FAIL rand_b_ctrl cyc=%0d got=%b/%b/%b exp=%b/%b/%b", n, b_busy, b_wr_err, b_dirty,
                           (m_left[1] > 0), m_we[1], m_dirty[1]); end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      m_init[0][i] = 12'(10 * (i + 1));
      m_init[1][i] = 12'(i + 1);
    end
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    @(posedge clk);
    #1;
    test_reset();
    test_defaults();
    test_write_read();
    test_restore();
    test_nonpow2();
    test_reset_mid_restore();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lit_init_reg_bank.md
Name: lit_init_reg_bank

Overview:
Parametrised register bank whose entries power up and reset to per-entry literal values supplied as a packed parameter. It generalises the fixed 4-bit literal-initialised register to DEPTH entries of WIDTH bits. It adds a write port, a registered read port, per-entry dirty tracking and a sequential "restore defaults" engine. It sits beside control/config logic as a small defaults-backed storage element.

Parameters:
WIDTH, 8, bits per entry (>=1)
DEPTH, 4, number of entries (>=2; need not be a power of two)
INIT_VALUES, {8'd40, 8'd30, 8'd20, 8'd10}, packed DEPTH*WIDTH literal; entry i is bits [i*WIDTH +: WIDTH] (entry 0 = 10, entry 1 = 20, entry 2 = 30, entry 3 = 40)
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_addr  input  AW  write entry index
wr_data  input  WIDTH  write data
rd_en  input  1  read request
rd_addr  input  AW  read entry index
rd_data  output  WIDTH  registered read data
rd_valid  output  1  one-cycle pulse; rd_data is valid
restore_req  input  1  start the restore-defaults sequence
busy  output  1  restore in progress
wr_err  output  1  one-cycle pulse; the previous cycle's write was rejected
dirty  output  DEPTH  bit i set means entry i has been written since its last reset/restore

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (reset). While reset is high:
  - every entry i = INIT_VALUES[i]
  - rd_data = 0, rd_valid = 0, busy = 0, wr_err = 0, dirty = 0
  - FSM = IDLE, restore index = 0
- FSM states: IDLE, RESTORE.
  - IDLE -> RESTORE on a rising edge with restore_req = 1. The index is set to 0 and busy = 1 from the next cycle.
  - In RESTORE, each edge: entry[idx] <= INIT_VALUES[idx], dirty[idx] <= 0, idx <= idx + 1.
  - RESTORE -> IDLE on the edge that restores idx = DEPTH-1. busy stays high for exactly DEPTH cycles.
  - restore_req while busy is ignored; no re-queue.
- Write acceptance (wr_en = 1 and busy = 0 and wr_addr < DEPTH):
  - entry[wr_addr] <= wr_data at that edge
  - dirty[wr_addr] <= 1
- Write rejection (wr_en = 1 and (busy = 1 or wr_addr >= DEPTH)):
  - storage and dirty are unchanged
  - wr_err = 1 for the following cycle only
  - wr_err is registered and is 0 otherwise
- Read:
  - rd_en = 1 -> on the next cycle rd_data = entry[rd_addr] as sampled pre-edge, and rd_valid = 1 for one cycle. Latency is 1.
  - rd_addr >= DEPTH returns 0 with rd_valid = 1.
  - rd_data holds its last value when rd_en = 0.
  - Reads are allowed during RESTORE and return the current, possibly partially restored, contents.
- Read and write to the same address in the same cycle: read returns the old value (read-before-write).
- Write accepted in the same cycle as restore_req in IDLE: the write lands, then the restore sequence overwrites that entry when idx reaches it.
- Width rules:
  - wr_data and rd_data are exactly WIDTH bits; no truncation or extension inside the bank.
  - idx is AW bits, compared against DEPTH-1. For non-power-of-two DEPTH it never reaches DEPTH.
- Reset asserted mid-restore: immediate return to full reset state (all entries at INIT, IDLE, busy = 0, dirty = 0), regardless of idx.

Test Plan:
1. Defaults (WIDTH=8, DEPTH=4): release reset; read addr 0..3 back-to-back -> rd_data 0x0A, 0x14, 0x1E, 0x28, each one cycle after rd_en with rd_valid pulsed; dirty = 4'b0000, busy = 0.
2. Write/read: write 0x55 to addr 2 -> dirty = 4'b0100. Same cycle, read addr 2 -> returns 0x1E. Next read of addr 2 -> 0x55.
3. Restore: after test 2, pulse restore_req one cycle -> busy high exactly 4 cycles. Write 0x77 to addr 1 during busy -> wr_err pulses one cycle, no change. After busy falls: addr 2 reads 0x1E, addr 1 reads 0x14, dirty = 0.
4. Non-power-of-two (WIDTH=12, DEPTH=5, INIT entries 0x001..0x005): write addr 6 -> wr_err pulse, dirty unchanged; read addr 6 -> rd_data 0x000 with rd_valid = 1; restore -> busy high 5 cycles.
5. Reset mid-restore: write 0xAA to addr 3, start restore, assert reset after 2 busy cycles -> busy = 0 and rd_valid = 0 immediately (asynchronously); after release, addr 3 reads 0x28 and dirty = 0.
6. Simultaneous: in IDLE, wr_en (addr 0, 0x99) with restore_req -> write accepted (no wr_err); busy rises next cycle; addr 0 reads 0x0A after restore completes.
